ccff_chain_loader: RTL

// Programming controller for the configuration-chain (ccff) flip-flops of a routing tile (CB/SB).

---
 rtl/ccff_chain_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Programming controller for the configuration flip-flop (ccff) chain of a
// routing tile. Configuration words arrive on a valid/ready stream and are
// serialised LSB-first into the chain head. The bits falling out of the chain
// tail are packed into readback words, so the block returns the chain's prior
// contents while it loads new ones.
//
// Ports
//   prog_clk    in   programming clock, all state on the rising edge
//   prog_reset  in   synchronous active-high reset
//   start       in   one-cycle pulse that begins a CHAIN_LEN-bit load (IDLE only)
//   cfg_data    in   configuration word, bit 0 shifted first
//   cfg_valid   in   cfg_data valid
//   cfg_ready   out  word accepted when cfg_valid & cfg_ready
//   ccff_head   out  registered serial data to the chain head
//   ccff_shift  out  registered chain clock enable
//   ccff_tail   in   serial data from the chain tail
//   rb_data     out  readback word, first tail bit in bit 0
//   rb_valid    out  rb_data valid, held stable until rb_ready
//   rb_ready    in   readback consumer ready
//   busy        out  high in any state other than IDLE
//   done        out  one-cycle pulse when the load and last readback complete
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]        state;
    logic [WORD_W-1:0] word_q;    // word currently being shifted out
    logic [WORD_W-1:0] rb_sr;     // tail bits collected for the current word
    logic [IDX_W-1:0]  bit_idx;   // bit position within the current word
    logic [CNT_W-1:0]  bit_cnt;   // bits shifted so far in this load
    logic [IDX_W-1:0]  next_idx;
    logic [WORD_W-1:0] rb_next;
    logic              word_end;
    logic              rb_take;
    logic              cfg_take;

    // A new word is only taken once the previous readback word has been
    // consumed (or is being consumed this cycle). Because shifting starts only
    // after an accept, the chain never moves while a readback word is pending.
    assign cfg_ready = (state == S_FETCH) && (!rb_valid || rb_ready);
    assign cfg_take  = cfg_valid && cfg_ready;
    assign rb_take   = rb_valid && rb_ready;
    assign busy      = (state != S_IDLE);

    // Word ends on its last bit, or early when the chain is full; any upper
    // bits of the final word are dropped and never reach the chain.
    assign word_end  = (bit_idx == LAST_IDX) || (bit_cnt == LAST_BIT);
    assign next_idx  = bit_idx + 1'b1;

    // NOTE: every signal assigned in always_comb receives a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rb_next          = rb_sr;
        rb_next[bit_idx] = ccff_tail;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state      <= S_IDLE;
            word_q     <= '0;
            rb_sr      <= '0;
            bit_idx    <= '0;
            bit_cnt    <= '0;
            ccff_head  <= 1'b0;
            ccff_shift <= 1'b0;
            rb_data    <= '0;
            rb_valid   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rb_take) begin
                rb_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        state   <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (cfg_take) begin
                        word_q     <= cfg_data;
                        ccff_head  <= cfg_data[0];
                        ccff_shift <= 1'b1;
                        bit_idx    <= '0;
                        rb_sr      <= '0;
                        state      <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    // ccff_shift is 1 throughout SHIFT: the chain moves on this
                    // edge and the tail bit seen now is the one leaving it.
                    rb_sr   <= rb_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (word_end) begin
                        ccff_shift <= 1'b0;
                        rb_data    <= rb_next;
                        rb_valid   <= 1'b1;
                        state      <= (bit_cnt == LAST_BIT) ? S_FLUSH : S_FETCH;
                    end else begin
                        bit_idx   <= next_idx;
                        ccff_head <= word_q[next_idx];
                    end
                end

                S_FLUSH: begin
                    if (rb_take) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
